// File: rtl/seq_detector_if.sv
// rtl/seq_detector_if.sv - serial sample in / match status out bundle for seq_detector
interface seq_detector_if #(
    parameter int CNT_W = 8
);
    logic             En;
    logic             Clr;
    logic             In1;
    logic             Out1;
    logic             Armed;
    logic [CNT_W-1:0] MatchCnt;

    modport master (
        output En, Clr, In1,
        input  Out1, Armed, MatchCnt
    );

    modport slave (
        input  En, Clr, In1,
        output Out1, Armed, MatchCnt
    );
endinterface

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - parametrised Moore serial pattern detector; SEQDET_MATCH_CNT_EN adds the saturating match counter
module seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input logic           CLK,
    input logic           RST,
    seq_detector_if.slave bus
);
    localparam int             FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d, hist_n;
    logic [FW-1:0]      fill_q, fill_d, fill_n;
    logic               out_q, out_d;
    logic               match;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    always_comb begin
        hist_n = {hist_q[PAT_LEN-2:0], bus.In1};
        fill_n = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        match  = (hist_n == PATTERN) && (fill_n == FULL);
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        if (bus.Clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bus.En) begin
            hist_d = hist_n;
            out_d  = match;
            // Non-overlap mode forgets history so the next match needs a full fresh window.
            fill_d = (match && !OVERLAP) ? '0 : fill_n;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.Clr) begin
            cnt_d = '0;
        end else if (bus.En && match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign bus.MatchCnt = cnt_q;
`else
    assign bus.MatchCnt = '0;
`endif

    assign bus.Out1  = out_q;
    assign bus.Armed = (fill_q == FULL);
endmodule
